// File: rtl/karatsuba_mult_stream.sv
// -----------------------------------------------------------------------------
// karatsuba_mult_stream
//
// Streaming unsigned Karatsuba-Ofman multiplier with valid/ready decoupling.
// The datapath is a free-running pipeline of 3*LEVEL register stages that
// never stalls. Admission is limited by a credit counter, so every operation
// that enters the pipeline already owns a slot in the output FIFO. Downstream
// backpressure therefore only fills the FIFO and never freezes the pipeline.
//
// Ports
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_dat_a, i_dat_b     unsigned operands (B is ignored when i_sqr=1)
//   i_sqr                1: compute A*A for this operation
//   i_val / o_rdy        input handshake
//   i_ctl                sideband tag that travels with the operation
//   o_val / i_rdy        output handshake
//   o_dat, o_ctl         product and tag at the FIFO head (held until consumed)
//   o_cnt                operations accepted and not yet consumed
// -----------------------------------------------------------------------------

// One Karatsuba level. The operands are split into halves. Three half-width
// products (lo*lo, hi*hi, |a_lo-a_hi|*|b_hi-b_lo|) are formed recursively,
// and the results are recombined. Latency is 3*LVL cycles from a_i/b_i to p_o.
//   stage 1 : split, absolute differences, middle-term sign
//   (sub-multipliers, 3*(LVL-1) cycles; native multiply at LVL==1)
//   stage 2 : middle term z1 = ll + hh +/- mm
//   stage 3 : p = hh<<W + z1<<H + ll
module karatsuba_core #(
   parameter int W   = 16,
   parameter int LVL = 1
) (
   input  logic           clk,
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   output logic [2*W-1:0] p_o
);
   localparam int H  = W / 2;
   localparam int SD = 3 * (LVL - 1);   // sub-multiplier latency

   logic [H-1:0] a_lo, a_hi, b_lo, b_hi, da, db;
   logic         sa, sb;

   assign a_lo = a_i[H-1:0];
   assign a_hi = a_i[W-1:H];
   assign b_lo = b_i[H-1:0];
   assign b_hi = b_i[W-1:H];

   // sa/sb record which difference went negative. The middle product
   // (a_lo-a_hi)*(b_hi-b_lo) is negative iff exactly one did.
   assign sa = a_lo < a_hi;
   assign sb = b_hi < b_lo;
   assign da = sa ? a_hi - a_lo : a_lo - a_hi;
   assign db = sb ? b_lo - b_hi : b_hi - b_lo;

   // Index 0 = low halves, 1 = high halves, 2 = middle term.
   logic [2:0][H-1:0] op_a_q, op_b_q;
   logic [SD:0]       sgn_q;

   always_ff @(posedge clk) begin
      op_a_q <= {da, a_hi, a_lo};
      op_b_q <= {db, b_hi, b_lo};
   end

   // The sign rides alongside the sub-products so that it arrives with them.
   if (SD > 0) begin : g_sgn_dly
      always_ff @(posedge clk) sgn_q <= {sgn_q[SD-1:0], sa ^ sb};
   end else begin : g_sgn_now
      always_ff @(posedge clk) sgn_q <= sa ^ sb;
   end

   wire [2:0][W-1:0] sub_p;

   for (genvar g = 0; g < 3; g++) begin : g_sub
      if (LVL == 1) begin : g_leaf
         assign sub_p[g] = W'(op_a_q[g]) * W'(op_b_q[g]);
      end else begin : g_rec
         karatsuba_core #(
            .W   (H),
            .LVL (LVL - 1)
         ) u_sub (
            .clk (clk),
            .a_i (op_a_q[g]),
            .b_i (op_b_q[g]),
            .p_o (sub_p[g])
         );
      end
   end

   // z1 = a_lo*b_hi + a_hi*b_lo < 2^(W+1). The true value is never negative.
   // Wrapping arithmetic in W+1 bits is therefore exact even when mm is
   // subtracted first.
   logic [W:0]     z1_d, z1_q;
   logic [2*W-1:0] hl_q, p_q;

   always_comb begin
      z1_d = {1'b0, sub_p[0]} + {1'b0, sub_p[1]};
      if (sgn_q[SD]) z1_d = z1_d - {1'b0, sub_p[2]};
      else           z1_d = z1_d + {1'b0, sub_p[2]};
   end

   always_ff @(posedge clk) begin
      z1_q <= z1_d;
      hl_q <= {sub_p[1], sub_p[0]};               // hh<<W + ll, no carry
      p_q  <= hl_q + ((2*W)'(z1_q) << H);
   end

   assign p_o = p_q;
endmodule

module karatsuba_mult_stream #(
   parameter int BITS       = 256,
   parameter int LEVEL      = 2,
   parameter int CTL_BITS   = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic [BITS-1:0]                   i_dat_a,
   input  logic [BITS-1:0]                   i_dat_b,
   input  logic                              i_sqr,
   input  logic                              i_val,
   input  logic [CTL_BITS-1:0]               i_ctl,
   output logic                              o_rdy,
   output logic                              o_val,
   output logic [CTL_BITS-1:0]               o_ctl,
   output logic [2*BITS-1:0]                 o_dat,
   input  logic                              i_rdy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_cnt
);
   localparam int LAT = 3 * LEVEL;
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int DW  = CTL_BITS + 2 * BITS;

   // ---------------------------------------------------------------- credits
   logic          run_q;        // low in reset, high from first edge after
   logic [CW-1:0] cnt_q, cnt_d;
   logic          acc, pop;
   logic          val_q;
   logic [CTL_BITS-1:0] ctl_q;
   logic [2*BITS-1:0]   dat_q;

   assign o_rdy = run_q && (cnt_q < CW'(FIFO_DEPTH));
   assign acc   = i_val && o_rdy;
   assign pop   = val_q && i_rdy;

   always_comb begin
      cnt_d = cnt_q;
      if (acc && !pop)      cnt_d = cnt_q + 1'b1;
      else if (!acc && pop) cnt_d = cnt_q - 1'b1;
   end

   // --------------------------------------------------------------- datapath
   logic [BITS-1:0]            b_eff;
   logic [2*BITS-1:0]          prod;
   logic [LAT:1]               vld_pipe;
   logic [LAT:1][CTL_BITS-1:0] ctl_pipe;

   assign b_eff = i_sqr ? i_dat_a : i_dat_b;

   karatsuba_core #(
      .W   (BITS),
      .LVL (LEVEL)
   ) u_core (
      .clk (i_clk),
      .a_i (i_dat_a),
      .b_i (b_eff),
      .p_o (prod)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) vld_pipe <= '0;
      else          vld_pipe <= {vld_pipe[LAT-1:1], acc};
   end

   always_ff @(posedge i_clk) ctl_pipe <= {ctl_pipe[LAT-1:1], i_ctl};

   // ------------------------------------------------------------ output FIFO
   // The output register is the FIFO head. mem_q holds the entries behind it.
   // When the head is free and mem_q is empty, a result leaving the pipeline
   // goes straight into the head register. This is still a registered path,
   // so o_val rises the cycle after the write.
   logic [DW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] mcnt_q, mcnt_d;
   logic          wr, load, from_mem, mem_wr;
   logic [DW-1:0] wr_dat;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign wr       = vld_pipe[LAT];
   assign wr_dat   = {ctl_pipe[LAT], prod};
   assign load     = !val_q || pop;
   assign from_mem = load && (mcnt_q != '0);
   assign mem_wr   = wr && !(load && (mcnt_q == '0));

   always_comb begin
      mcnt_d = mcnt_q;
      if (mem_wr && !from_mem)      mcnt_d = mcnt_q + 1'b1;
      else if (!mem_wr && from_mem) mcnt_d = mcnt_q - 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (mem_wr) mem_q[wptr_q] <= wr_dat;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         run_q  <= 1'b0;
         cnt_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         mcnt_q <= '0;
         val_q  <= 1'b0;
         ctl_q  <= '0;
         dat_q  <= '0;
      end else begin
         run_q  <= 1'b1;
         cnt_q  <= cnt_d;
         mcnt_q <= mcnt_d;
         if (mem_wr)   wptr_q <= ptr_inc(wptr_q);
         if (from_mem) rptr_q <= ptr_inc(rptr_q);
         if (load) begin
            if (from_mem) begin
               {ctl_q, dat_q} <= mem_q[rptr_q];
               val_q          <= 1'b1;
            end else if (wr) begin
               {ctl_q, dat_q} <= wr_dat;
               val_q          <= 1'b1;
            end else begin
               val_q <= 1'b0;
            end
         end
      end
   end

   assign o_val = val_q;
   assign o_ctl = ctl_q;
   assign o_dat = dat_q;
   assign o_cnt = cnt_q;
endmodule
